// File: rtl/mem_dump_tx.sv
// Streams DUMP_BYTES consecutive bytes of a 1-cycle-latency byte RAM out over UART TX (8N1, LSB first).
// Define MEM_DUMP_CHECKSUM_EN to append a mod-256 checksum frame after the data bytes.
module mem_dump_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 9,
  parameter int DUMP_BYTES   = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_ra,
  input  logic [7:0]        mem_rd,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = (DUMP_BYTES > 1) ? $clog2(DUMP_BYTES + 1) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  BYTE_LAST = CNT_W'(DUMP_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_START, S_DATA, S_STOP, S_DONE, S_CSUM
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  byte_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]        sum;
  logic              csum_phase;
`endif

  // tx is registered, so each transition loads the level of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      addr     <= '0;
      byte_cnt <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      mem_ra   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum        <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (start) begin
            addr     <= base_addr;
            mem_ra   <= base_addr;
            byte_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_READ;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum        <= '0;
            csum_phase <= 1'b0;
`endif
          end
        end
        S_READ: state <= S_LATCH;
        S_LATCH: begin
          shreg    <= mem_rd;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= S_START;
`ifdef MEM_DUMP_CHECKSUM_EN
          sum <= sum + mem_rd;
`endif
        end
        S_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            if (csum_phase) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else if (byte_cnt == BYTE_LAST) begin
              state <= S_CSUM;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              addr     <= addr + 1'b1;
              mem_ra   <= addr + 1'b1;
              state    <= S_READ;
            end
`else
            if (byte_cnt == BYTE_LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              addr     <= addr + 1'b1;
              mem_ra   <= addr + 1'b1;
              state    <= S_READ;
            end
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        // Two cycles here keep the same idle-high gap as READ+LATCH.
        S_CSUM: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_W'(1);
          end else begin
            baud_cnt   <= '0;
            shreg      <= sum;
            csum_phase <= 1'b1;
            tx         <= 1'b0;
            state      <= S_START;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Randomized scoreboard bench for mem_dump_tx: a UART decoder monitor checks every frame against a queue.
module tb_mem_dump_tx;
  localparam int C  = 4;
  localparam int AW = 9;
  localparam int DB = 4;
  localparam int N  = 1 << AW;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] mem_ra;
  logic [7:0]    mem_rd = '0;
  logic          tx, busy, done;
  logic [7:0]    mem [N];

  mem_dump_tx #(.CLKS_PER_BIT(C), .ADDR_W(AW), .DUMP_BYTES(DB)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .mem_ra(mem_ra), .mem_rd(mem_rd), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_rd <= mem[mem_ra];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    bit         first;
    bit         last;
    int         t0;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;
  int done_seen = 0, exp_dones = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: a dump is DB consecutive bytes modulo the address space, plus an optional sum frame.
  task automatic push_dump(input int base, input int t0);
    logic [7:0] sum = 8'h00;
    for (int i = 0; i < DB; i++) begin
      logic [7:0] b = mem[(base + i) % N];
      sum = sum + b;
      q.push_back('{b, i == 0, (i == DB - 1) && !CS, t0});
    end
    if (CS) q.push_back('{sum, 1'b0, 1'b1, t0});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int base);
    start = 1'b1;
    base_addr = AW'(base);
    push_dump(base, cyc);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    chk("idle_timeout", 32'(n < 3000), 1);
    tick();
    tick();
  endtask

  // Monitor: UART decoder sampling mid-bit on the falling clock edge.
  initial begin
    int ph = -1;
    int prev = 0;
    int k;
    bit pend = 1'b0;
    exp_t e;
    logic [7:0] rx = '0;
    e = '{8'h00, 1'b0, 1'b0, 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        ph = -1;
        pend = 1'b0;
      end else begin
        if (done) done_seen++;
        if (pend) begin
          chk("busy_after_done", 32'(busy), 0);
          chk("done_width", 32'(done), 0);
          pend = 1'b0;
        end
        if (ph < 0) begin
          if (tx == 1'b0) begin
            ph = 0;
            if (q.size() == 0) begin
              chk("unexpected_frame", 1, 0);
              e = '{8'h00, 1'b0, 1'b0, 0};
            end else begin
              e = q.pop_front();
              if (e.first) chk("start_latency", 32'(cyc - e.t0), 3);
              else         chk("frame_gap", 32'(cyc - prev), 10 * C + 2);
            end
            prev = cyc;
          end
        end else begin
          ph++;
          if (ph >= C / 2 && (ph - C / 2) % C == 0 && (ph - C / 2) / C <= 9) begin
            k = (ph - C / 2) / C;
            if (k == 0)      chk("start_bit", 32'(tx), 0);
            else if (k <= 8) rx[k-1] = tx;
            else begin
              chk("stop_bit", 32'(tx), 1);
              chk("byte", 32'(rx), 32'(e.d));
            end
          end
          if (ph == 10 * C) begin
            chk("done_at_end", 32'(done), 32'(e.last));
            chk("busy_in_frame", 32'(busy), 1);
            pend = e.last;
            ph = -1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h55; mem[3] = 8'h80;
    mem[9'h010] = 8'hA5;

    repeat (3) tick();
    @(negedge clk);
    chk("reset_tx", 32'(tx), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_mem_ra", 32'(mem_ra), 0);
    reset = 1'b0;
    tick();

    issue(0);         wait_idle(); exp_dones++;
    issue(9'h010);    wait_idle(); exp_dones++;
    issue(9'h1FE);    wait_idle(); exp_dones++;
    for (int r = 0; r < 4; r++) begin
      issue($urandom_range(0, N - 1));
      wait_idle();
      exp_dones++;
    end

    // start while busy must not disturb the running dump
    issue(9'h040);
    repeat (60) tick();
    start = 1'b1; base_addr = 9'h100;
    tick();
    start = 1'b0;
    repeat (50) tick();
    start = 1'b1; base_addr = 9'h133;
    tick();
    start = 1'b0;
    wait_idle(); exp_dones++;

    // start coincident with done is ignored; the following cycle is accepted
    issue(9'h020);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    chk("done_wait_timeout", 32'(n < 3000), 1);
    start = 1'b1; base_addr = 9'h150;
    tick();
    base_addr = 9'h0A0;
    push_dump(9'h0A0, cyc);
    tick();
    start = 1'b0;
    wait_idle(); exp_dones += 2;

    // reset during DATA bit 3 truncates the frame
    issue(9'h077);
    repeat (19) tick();
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midreset_tx", 32'(tx), 1);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_done", 32'(done), 0);
    reset = 1'b0;
    tick();
    tick();
    issue(9'h1C3);    wait_idle(); exp_dones++;

    chk("done_count", 32'(done_seen), 32'(exp_dones));
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
